// File: rtl/multdiv_iter_if.sv
// multdiv_iter_if: command/operand and result bundle for the iterative multiply/divide engine
interface multdiv_iter_if #(parameter int WIDTH = 32);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply (radix-4 Booth) / divide (non-restoring on magnitudes)
module multdiv_iter #(
   parameter int WIDTH = 32
) (
   input logic        clock,
   input logic        clrn,
   multdiv_iter_if.slave bus
);
   localparam int SW = $clog2(WIDTH) + 1;
   localparam logic [SW-1:0] MUL_LAST = SW'(WIDTH / 2 - 1);
   localparam logic [SW-1:0] DIV_LAST = SW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state_q, state_d;
   logic [SW-1:0]      step_q, step_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mul_q, mul_d;
   logic               qm1_q, qm1_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               neg_q, neg_d;
   logic               dz_q, dz_d;
   logic               ovf_q, ovf_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;
   logic               busy_q, busy_d;

   logic               start_mul, start_div, a_neg, b_neg, b_zero, div_ovf;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2:0]         booth;
   logic [2*WIDTH-1:0] mc2, pp;
   logic [WIDTH:0]     shifted, rem_n;
   logic [WIDTH:0]     prod_hi;

   // MULT takes priority when both commands arrive together
   assign start_mul = bus.ctrl_MULT;
   assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
   assign a_neg     = bus.data_operandA[WIDTH-1];
   assign b_neg     = bus.data_operandB[WIDTH-1];
   assign a_mag     = a_neg ? -bus.data_operandA : bus.data_operandA;
   assign b_mag     = b_neg ? -bus.data_operandB : bus.data_operandB;
   assign b_zero    = bus.data_operandB == '0;
   assign div_ovf   = (bus.data_operandA == MIN_INT) && (&bus.data_operandB);

   // Booth digit from the two low multiplier bits plus the bit shifted out last step
   assign booth = {mul_q[1:0], qm1_q};
   assign mc2   = mcand_q << 1;
   assign pp    = (booth == 3'b001 || booth == 3'b010) ? mcand_q :
                  (booth == 3'b011)                    ? mc2 :
                  (booth == 3'b100)                    ? -mc2 :
                  (booth == 3'b101 || booth == 3'b110) ? -mcand_q : '0;

   // Partial remainder stays within W signed bits, so its top bit can be dropped on shift
   assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign rem_n   = rem_q[WIDTH] ? shifted + {1'b0, dvs_q} : shifted - {1'b0, dvs_q};

   // Product overflows unless the top W+1 bits are a pure sign extension
   assign prod_hi = acc_q[2*WIDTH-1:WIDTH-1];

   // Next-state, datapath and registered-output logic; any start aborts the current op
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mul_d    = mul_q;
      qm1_d    = qm1_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      is_div_d = is_div_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      busy_d   = (state_q == MUL) || (state_q == DIV);
      if (start_mul) begin
         state_d  = MUL;
         step_d   = '0;
         acc_d    = '0;
         mcand_d  = {{WIDTH{a_neg}}, bus.data_operandA};
         mul_d    = bus.data_operandB;
         qm1_d    = 1'b0;
         is_div_d = 1'b0;
         busy_d   = 1'b1;
      end else if (start_div) begin
         state_d  = b_zero ? DONE : DIV;
         step_d   = '0;
         rem_d    = '0;
         quo_d    = a_mag;
         dvs_d    = b_mag;
         neg_d    = a_neg ^ b_neg;
         dz_d     = b_zero;
         ovf_d    = div_ovf;
         is_div_d = 1'b1;
         busy_d   = 1'b1;
      end else begin
         case (state_q)
            MUL: begin
               acc_d   = acc_q + pp;
               mcand_d = mcand_q << 2;
               mul_d   = {{2{mul_q[WIDTH-1]}}, mul_q[WIDTH-1:2]};
               qm1_d   = mul_q[1];
               step_d  = (step_q == MUL_LAST) ? step_q : step_q + SW'(1);
               state_d = (step_q == MUL_LAST) ? DONE : MUL;
            end
            DIV: begin
               rem_d   = rem_n;
               quo_d   = {quo_q[WIDTH-2:0], ~rem_n[WIDTH]};
               step_d  = (step_q == DIV_LAST) ? step_q : step_q + SW'(1);
               state_d = (step_q == DIV_LAST) ? DONE : DIV;
            end
            DONE: begin
               state_d  = IDLE;
               rdy_d    = 1'b1;
               result_d = !is_div_q ? acc_q[WIDTH-1:0] : dz_q ? '0 : neg_q ? -quo_q : quo_q;
               exc_d    = is_div_q ? (dz_q | ovf_q) : !((&prod_hi) || (~|prod_hi));
            end
            default: ;
         endcase
      end
   end

   // Sequencing FSM and datapath registers
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         step_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mul_q    <= '0;
         qm1_q    <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         is_div_q <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mul_q    <= mul_d;
         qm1_q    <= qm1_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         is_div_q <= is_div_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;
endmodule
